// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with valid/ready output, flush and overflow.
// Optional sticky overflow flop: define SIPO_OVERFLOW_FLAG_EN.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst_l,
  input  logic             Serial_In,
  input  logic             Valid_I,
  input  logic             Clear_I,
  input  logic             Ready_I,
  output logic [WIDTH-1:0] Parallel_Out,
  output logic             Valid_O,
  output logic             Busy_O,
  output logic             Overflow_O
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  out_state_t state, state_nxt;

  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sh, sh_nxt, shifted;
  logic             done;
  logic             load;

  always_comb begin
    if (MSB_FIRST) shifted = {sh[WIDTH-2:0], Serial_In};
    else           shifted = {Serial_In, sh[WIDTH-1:1]};
  end

  // Clear outranks a sample arriving on the same edge
  always_comb begin
    sh_nxt  = sh;
    cnt_nxt = cnt;
    done    = 1'b0;
    if (Clear_I) begin
      sh_nxt  = '0;
      cnt_nxt = '0;
    end else if (Valid_I) begin
      sh_nxt = shifted;
      if (cnt == LAST) begin
        cnt_nxt = '0;
        done    = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (done) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (Ready_I) begin
          if (done) load      = 1'b1;
          else      state_nxt = EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      state        <= EMPTY;
      cnt          <= '0;
      sh           <= '0;
      Parallel_Out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sh    <= sh_nxt;
      if (load) Parallel_Out <= sh_nxt;
    end
  end

  assign Valid_O = (state == FULL);
  assign Busy_O  = (cnt != '0);

`ifdef SIPO_OVERFLOW_FLAG_EN
  logic drop;
  logic ovf;

  assign drop = (state == FULL) && !Ready_I && done;

  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l)       ovf <= 1'b0;
    else if (Clear_I) ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
  end

  assign Overflow_O = ovf;
`else
  assign Overflow_O = 1'b0;
`endif

endmodule
